// File: rtl/parallel_shiftregister.sv
// ============================================================================
// parallel_shiftregister : PISO serializer plus PIPO holding register
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module parallel_shiftregister #(
    parameter int   WIDTH     = 4,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic FILL_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    input  logic             en,
    output logic             sout_piso,
    output logic [WIDTH-1:0] pout
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted   = {shreg_q[WIDTH-2:0], FILL_BIT};
            assign sout_piso = shreg_q[WIDTH-1];
        end else begin : g_lsb_first
            assign shifted   = {FILL_BIT, shreg_q[WIDTH-1:1]};
            assign sout_piso = shreg_q[0];
        end
    endgenerate

    // Load wins over shift every cycle; count saturates once the word is drained.
    always_comb begin
        shreg_d = shreg_q;
        pout_d  = pout_q;
        count_d = count_q;
        if (en) begin
            shreg_d = pin;
            pout_d  = pin;
            count_d = '0;
        end else begin
            shreg_d = shifted;
            if (count_q != CNT_MAX) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            pout_q  <= '0;
            count_q <= '0;
        end else begin
            shreg_q <= shreg_d;
            pout_q  <= pout_d;
            count_q <= count_d;
        end
    end

    assign pout = pout_q;

    a_count_bound : assert property (@(posedge clk) disable iff (!rst) count_q <= CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_parallel_shiftregister.sv
// ============================================================================
// tb_parallel_shiftregister : scoreboard bench for parallel_shiftregister
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_parallel_shiftregister;

    logic       clk;
    logic       rst;
    logic [3:0] pin;
    logic       en;
    logic       sout_piso;
    logic [3:0] pout;

    typedef struct packed {
        logic       sout;
        logic [3:0] pout;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   step_no;

    parallel_shiftregister #(
        .WIDTH    (4),
        .MSB_FIRST(1'b1),
        .FILL_BIT (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pin      (pin),
        .en       (en),
        .sout_piso(sout_piso),
        .pout     (pout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Drive one edge's inputs on the falling edge and queue the response due after the next rising edge.
    task automatic step(input logic r, input logic e, input logic [3:0] p,
                        input logic es, input logic [3:0] ep);
        exp_t item;
        @(negedge clk);
        rst = r;
        en  = e;
        pin = p;
        item.sout = es;
        item.pout = ep;
        exp_q.push_back(item);
    endtask

    initial begin : monitor
        exp_t item;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                step_no++;
                check($sformatf("sout step %0d", step_no), {3'b000, sout_piso}, {3'b000, item.sout});
                check($sformatf("pout step %0d", step_no), pout, item.pout);
            end
        end
    end

    initial begin : driver
        checks  = 0;
        errors  = 0;
        step_no = 0;
        rst = 1'b0;
        en  = 1'b1;
        pin = 4'b1111;
        #1;
        check("reset sout at t0", {3'b000, sout_piso}, 4'b0000);
        check("reset pout at t0", pout, 4'b0000);

        // Reset held with load requested and clocks running
        step(1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000);

        // Load 1011, shift 8; pin wiggles during shifting must be ignored
        step(1'b1, 1'b1, 4'b1011, 1'b1, 4'b1011);
        step(1'b1, 1'b0, 4'b0101, 1'b0, 4'b1011);
        step(1'b1, 1'b0, 4'b1111, 1'b1, 4'b1011);
        step(1'b1, 1'b0, 4'b0000, 1'b1, 4'b1011);
        step(1'b1, 1'b0, 4'b1001, 1'b0, 4'b1011);
        step(1'b1, 1'b0, 4'b1111, 1'b0, 4'b1011);
        step(1'b1, 1'b0, 4'b1111, 1'b0, 4'b1011);
        step(1'b1, 1'b0, 4'b1111, 1'b0, 4'b1011);
        step(1'b1, 1'b0, 4'b1111, 1'b0, 4'b1011);

        // Load 1100, shift 8
        step(1'b1, 1'b1, 4'b1100, 1'b1, 4'b1100);
        step(1'b1, 1'b0, 4'b0000, 1'b1, 4'b1100);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b1100);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b1100);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b1100);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b1100);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b1100);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b1100);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b1100);

        // Reload mid-shift
        step(1'b1, 1'b1, 4'b1011, 1'b1, 4'b1011);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b1011);
        step(1'b1, 1'b0, 4'b0000, 1'b1, 4'b1011);
        step(1'b1, 1'b1, 4'b0110, 1'b0, 4'b0110);
        step(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0110);
        step(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0110);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0110);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0110);

        // en stuck high: every edge reloads
        step(1'b1, 1'b1, 4'b0001, 1'b0, 4'b0001);
        step(1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000);
        step(1'b1, 1'b1, 4'b0111, 1'b0, 4'b0111);

        // Asynchronous reset in the middle of a word
        step(1'b1, 1'b1, 4'b1011, 1'b1, 4'b1011);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b1011);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async reset sout", {3'b000, sout_piso}, 4'b0000);
        check("async reset pout", pout, 4'b0000);
        step(1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0101, 1'b0, 4'b0101);
        step(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0101);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0101);
        step(1'b1, 1'b0, 4'b0000, 1'b1, 4'b0101);
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0101);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
